fir_block_serializer: RTL
=========================

Name: fir_block_serializer

Overview:
- Single-clock parallel-to-serial stage for L-parallel FIR outputs.
- Accepts one L-sample block per handshake from a parallel FIR core, buffers up to two blocks, and emits one sample per handshake in time order, lane 0 first.
- Replaces the dual-clock output mux: the whole datapath runs on one clock with valid/ready flow control on both sides.

Parameters:
- L, 2, parallelism factor (samples per block); legal values 2..4.
- DW, 24, sample width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  global enable; when low, all state is frozen.
- blk_in  input  L*DW  block of samples; lane k occupies bits [k*DW+DW-1 : k*DW]; lane 0 is the earliest sample.
- blk_valid  input  1  blk_in is valid.
- blk_ready  output  1  block buffer can accept a block.
- data_out  output  DW  current serial sample.
- out_valid  output  1  data_out is valid.
- out_ready  input  1  downstream accepts data_out.
- underrun_cnt  output  16  underrun statistic (see Optional Feature).

Behaviour:
- Storage:
  - Two block entries, mem[0..1], each L*DW bits.
  - wr_ptr (1 bit), rd_ptr (1 bit), count (0..2), lane (0..L-1).
- Reset (reset=0, asynchronous):
  - count, wr_ptr, rd_ptr and lane go to 0; underrun_cnt goes to 0.
  - Outputs are blk_ready=0, out_valid=0, data_out=0.
  - Buffered contents are discarded. Reset asserted mid-block drops the remaining lanes.
  - Deassertion is used synchronously to clk.
- Handshake outputs (combinational from registers):
  - blk_ready = en & (count<2).
  - out_valid = en & (count!=0).
  - data_out = lane `lane` of mem[rd_ptr] when count!=0, else 0.
- Push: when blk_valid & blk_ready, mem[wr_ptr] <= blk_in and wr_ptr toggles.
- Pop: when out_valid & out_ready:
  - if lane==L-1, lane <= 0 and rd_ptr toggles (block retired);
  - otherwise lane <= lane+1.
- count update:
  - +1 on push; -1 on block retire.
  - Both in the same cycle leaves count unchanged.
  - A push while count==2 is impossible because blk_ready=0; no same-cycle bypass from full.
- Latency:
  - A block accepted at edge N produces its lane 0 on data_out with out_valid=1 after edge N.
  - With out_ready held high, an L-sample block drains in L cycles.
  - Sustained throughput is 1 sample/cycle whenever blk_valid is presented at least once per L cycles.
- en=0:
  - No push, pop, or counter updates.
  - blk_ready=0 and out_valid=0.
  - Registers hold their values; resuming en continues from the same lane.
- out_ready low holds data_out and lane stable; no sample is skipped or repeated.
- Arithmetic: none on samples; data passes bit-exact.

Optional Feature:
- Macro: FIR_SER_UNDERRUN_CNT_EN.
- Defined:
  - underrun_cnt is a 16-bit saturating counter, incremented on each cycle with en=1, out_ready=1 and count==0.
  - It holds at 16'hFFFF once saturated and is cleared only by reset.
- Undefined: the counter logic is not built and underrun_cnt is tied to 16'd0.

Test Plan (L=2, DW=24):
- Reset, then single block 0x000002_000001 with out_ready=1 → data_out sequence 0x000001, 0x000002 on consecutive cycles; out_valid then falls to 0; blk_ready=1 throughout.
- out_ready=0; push blocks A then B → count=2, blk_ready=0 and a third blk_valid is ignored. Release out_ready → A.lane0, A.lane1, B.lane0, B.lane1 in order, with no loss.
- Continuous blk_valid every 2 cycles, out_ready=1 → gap-free output at 1 sample/cycle. Checker verifies samples 1..100 in order.
- Drop en mid-block after A.lane0 for 5 cycles → out_valid=0 and blk_ready=0 during the gap; A.lane1 is emitted first after en returns.
- Assert reset with count=2, lane=1 → outputs are 0 immediately (asynchronous). After release, a new block emits its own lane 0 first, with no stale data.
- With FIR_SER_UNDERRUN_CNT_EN defined: out_ready=1, buffer empty for 10 cycles → underrun_cnt=10. Without the macro the same stimulus gives underrun_cnt=0.

Source files
------------

// File: rtl/fir_block_serializer.sv
// fir_block_serializer: two-entry L-sample block buffer drained one sample per handshake, lane 0 first.
// Define FIR_SER_UNDERRUN_CNT_EN to build the saturating underrun counter on o_underrun_cnt.
module fir_block_serializer #(
    parameter int L  = 2,
    parameter int DW = 24
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic [L*DW-1:0] i_blk_in,
    input  logic            i_blk_valid,
    output logic            o_blk_ready,
    output logic [DW-1:0]   o_data_out,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [15:0]     o_underrun_cnt
);

    localparam int            LW        = (L > 2) ? 2 : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(L - 1);

    logic [L*DW-1:0] r_mem [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic [LW-1:0]   r_lane;

    logic            w_push;
    logic            w_pop;
    logic            w_retire;
    logic [L*DW-1:0] w_rd_blk;
    logic [DW-1:0]   w_lanes [L];

    // Ready is also gated by reset so upstream sees no acceptance while reset is held.
    assign o_blk_ready = i_rst_n & i_en & (r_count != 2'd2);
    assign o_out_valid = i_en & (r_count != 2'd0);

    assign w_push   = i_blk_valid & o_blk_ready;
    assign w_pop    = o_out_valid & i_out_ready;
    assign w_retire = w_pop & (r_lane == LANE_LAST);

    assign w_rd_blk = r_mem[r_rd_ptr];

    genvar k;
    generate
        for (k = 0; k < L; k++) begin : g_lane
            assign w_lanes[k] = w_rd_blk[k*DW +: DW];
        end
    endgenerate

    assign o_data_out = (r_count != 2'd0) ? w_lanes[r_lane] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_blk_in;
            r_wr_ptr        <= ~r_wr_ptr;
        end
    end

    // Lane walks through the head block; the last lane retires the block and moves to the other entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane   <= '0;
            r_rd_ptr <= 1'b0;
        end else if (w_pop) begin
            if (r_lane == LANE_LAST) begin
                r_lane   <= '0;
                r_rd_ptr <= ~r_rd_ptr;
            end else begin
                r_lane <= r_lane + LW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_retire})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIR_SER_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    // Counts cycles where downstream wanted a sample but the buffer was empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_underrun_cnt <= 16'd0;
        end else if (i_en && i_out_ready && (r_count == 2'd0) && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign o_underrun_cnt = r_underrun_cnt;
`else
    assign o_underrun_cnt = 16'd0;
`endif

endmodule
